// File: rtl/fpu_iter_multiplier_if.sv
// Operand/result handshake bundle for fpu_iter_multiplier.
// master drives operands and consumes results; slave is the multiplier.
interface fpu_iter_multiplier_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0]   mulIn1;
    logic [WIDTH-1:0]   mulIn2;
    logic               inValid;
    logic               inReady;
    logic               flush;
    logic [2*WIDTH-1:0] mulOut;
    logic               outValid;
    logic               outReady;
    logic               busy;

    modport master (
        output mulIn1, mulIn2, inValid, flush, outReady,
        input  inReady, mulOut, outValid, busy
    );

    modport slave (
        input  mulIn1, mulIn2, inValid, flush, outReady,
        output inReady, mulOut, outValid, busy
    );
endinterface

// File: rtl/fpu_iter_multiplier.sv
// Iterative unsigned multiplier retiring RADIX_BITS multiplier bits per cycle.
// Optional early termination on an exhausted multiplier: macro FPU_MUL_EARLY_TERM_EN.
module fpu_iter_multiplier #(
    parameter int WIDTH      = 24,
    parameter int RADIX_BITS = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    fpu_iter_multiplier_if.slave  bus
);
    localparam int OUTWIDTH = 2 * WIDTH;
    localparam int ITERS    = (WIDTH + RADIX_BITS - 1) / RADIX_BITS;
    localparam int PADW     = ITERS * RADIX_BITS;
    localparam int PPW      = WIDTH + RADIX_BITS;
    localparam int CNTW     = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int SHW      = $clog2(OUTWIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [PADW-1:0]      mplier_r;
    logic [OUTWIDTH-1:0]  acc_r;
    logic [CNTW-1:0]      count_r;
    logic [OUTWIDTH-1:0]  mul_out_r;
    logic                 out_valid_r;
    logic                 busy_r;

    logic                 accept_s;
    logic                 step_s;
    logic                 last_s;
    logic [RADIX_BITS-1:0] digit_s;
    logic [PPW-1:0]       pp_s;
    logic [SHW-1:0]       shamt_s;
    logic [OUTWIDTH-1:0]  pp_ext_s;
    logic [OUTWIDTH-1:0]  acc_sum_s;
    logic [PADW-1:0]      mplier_shift_s;

    // The top digit may be partial; zero padding of mplier_r keeps it exact,
    // and every partial sum is bounded by the final product so OUTWIDTH never overflows.
    assign digit_s        = mplier_r[RADIX_BITS-1:0];
    assign pp_s           = PPW'(mcand_r) * PPW'(digit_s);
    assign shamt_s        = SHW'(count_r) * SHW'(RADIX_BITS);
    assign pp_ext_s       = OUTWIDTH'(pp_s) << shamt_s;
    assign acc_sum_s      = acc_r + pp_ext_s;
    assign mplier_shift_s = mplier_r >> RADIX_BITS;

`ifdef FPU_MUL_EARLY_TERM_EN
    assign last_s = (mplier_shift_s == {PADW{1'b0}}) || (count_r == CNTW'(ITERS - 1));
`else
    assign last_s = (count_r == CNTW'(ITERS - 1));
`endif

    assign bus.inReady  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.outReady);
    assign bus.mulOut   = mul_out_r;
    assign bus.outValid = out_valid_r;
    assign bus.busy     = busy_r;

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; flush overrides any acceptance or step.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.inValid) begin
                        state_nxt_s = ST_COMP;
                        accept_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_COMP: begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_COMP;
                    end
                end
                ST_DONE: begin
                    if (bus.outReady) begin
                        if (bus.inValid) begin
                            state_nxt_s = ST_COMP;
                            accept_s    = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Operand latch and shift-add accumulation.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {PADW{1'b0}};
            acc_r    <= {OUTWIDTH{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else if (accept_s) begin
            mcand_r  <= bus.mulIn1;
            mplier_r <= PADW'(bus.mulIn2);
            acc_r    <= {OUTWIDTH{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else if (step_s) begin
            acc_r    <= acc_sum_s;
            mplier_r <= mplier_shift_s;
            count_r  <= count_r + CNTW'(1'b1);
        end else begin
            acc_r    <= acc_r;
            mplier_r <= mplier_r;
            count_r  <= count_r;
        end
    end

    // Registered result and status; mulOut only changes when a product completes.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mul_out_r   <= {OUTWIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (step_s && last_s) begin
                mul_out_r <= acc_sum_s;
            end else begin
                mul_out_r <= mul_out_r;
            end
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_COMP);
        end
    end
endmodule

// File: tb/tb_fpu_iter_multiplier.sv
// Randomized and directed bench for fpu_iter_multiplier with an in-bench
// transaction-level model checked against the DUT on every falling edge.
module tb_fpu_iter_multiplier;
    localparam int W     = 24;
    localparam int R     = 4;
    localparam int ITERS = 6;

`ifdef FPU_MUL_EARLY_TERM_EN
    localparam int LAT_3X5  = 1;
    localparam int LAT_X10  = 2;
`else
    localparam int LAT_3X5  = 6;
    localparam int LAT_X10  = 6;
`endif

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    fpu_iter_multiplier_if #(.WIDTH(W))  bus ();
    fpu_iter_multiplier_if #(.WIDTH(23)) bus23 ();

    fpu_iter_multiplier #(.WIDTH(W), .RADIX_BITS(R)) u_dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    fpu_iter_multiplier #(.WIDTH(23), .RADIX_BITS(R)) u_dut23 (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus23)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_prod(input logic [23:0] a, input logic [23:0] b);
        return {24'd0, a} * {24'd0, b};
    endfunction

    function automatic int exp_lat(input logic [23:0] b);
`ifdef FPU_MUL_EARLY_TERM_EN
        int n = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) n = i + 1;
        end
        return (n == 0) ? 1 : (n + R - 1) / R;
`else
        return ITERS;
`endif
    endfunction

    // Transaction-level model: cycles left in the current product and the pending result.
    int          m_left   = 0;
    bit          m_have   = 1'b0;
    logic [47:0] m_pend   = 48'd0;
    logic [47:0] m_result = 48'd0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_left <= 0;
            m_have <= 1'b0;
        end else if (bus.flush) begin
            m_left <= 0;
            m_have <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_have   <= 1'b1;
                m_result <= m_pend;
            end
        end else if (bus.inValid && (!m_have || bus.outReady)) begin
            m_left <= exp_lat(bus.mulIn2);
            m_pend <= model_prod(bus.mulIn1, bus.mulIn2);
            m_have <= 1'b0;
        end else if (m_have && bus.outReady) begin
            m_have <= 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clock) begin
        if (!resetN) begin
            chk("rst_mulOut",   64'(bus.mulOut),   64'd0);
            chk("rst_outValid", 64'(bus.outValid), 64'd0);
            chk("rst_busy",     64'(bus.busy),     64'd0);
            chk("rst_inReady",  64'(bus.inReady),  64'd1);
        end else begin
            chk("outValid", 64'(bus.outValid), 64'(m_have));
            chk("busy",     64'(bus.busy),     64'(m_left > 0));
            chk("inReady",  64'(bus.inReady),
                64'((m_left == 0 && !m_have) || (m_have && bus.outReady)));
            if (m_have) chk("mulOut", 64'(bus.mulOut), 64'(m_result));
        end
    end

    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        bus.mulIn1  = a;
        bus.mulIn2  = b;
        bus.inValid = 1'b1;
        for (int i = 0; i < 50 && !bus.inReady; i++) begin
            @(posedge clock); #1;
        end
        chk("accept_ready", 64'(bus.inReady), 64'd1);
        @(posedge clock); #1;
        bus.inValid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.outValid && edges < 60) begin
            @(posedge clock); #1;
            edges++;
        end
        chk("valid_timeout", 64'(bus.outValid), 64'd1);
    endtask

    task automatic consume();
        bus.outReady = 1'b1;
        @(posedge clock); #1;
        bus.outReady = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] lit_prod, input int lit_lat);
        int e;
        chk({name, "_model_prod"}, 64'(model_prod(a, b)), 64'(lit_prod));
        chk({name, "_model_lat"},  64'(exp_lat(b)),       64'(lit_lat));
        start_op(a, b);
        wait_valid(e);
        chk({name, "_latency"}, 64'(e), 64'(lit_lat));
        chk({name, "_product"}, 64'(bus.mulOut), 64'(lit_prod));
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e;
        bus.mulIn1 = 24'd0; bus.mulIn2 = 24'd0; bus.inValid = 1'b0;
        bus.flush  = 1'b0;  bus.outReady = 1'b0;
        bus23.mulIn1 = 23'd0; bus23.mulIn2 = 23'd0; bus23.inValid = 1'b0;
        bus23.flush  = 1'b0;  bus23.outReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;
        @(posedge clock); #1;

        do_op("max",  24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 6);
        do_op("3x5",  24'h000003, 24'h000005, 48'h00000000000F, LAT_3X5);
        do_op("zero", 24'hABCDEF, 24'h000000, 48'h000000000000, exp_lat(24'h0));

        // Result held for 10 cycles with outReady low.
        start_op(24'h800000, 24'h800000);
        wait_valid(e);
        chk("hold_latency", 64'(e), 64'd6);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(bus.outValid), 64'd1);
            chk("hold_mulOut", 64'(bus.mulOut), 64'h400000000000);
            @(posedge clock); #1;
        end
        consume();

        // Back-to-back: inValid and outReady held high.
        bus.outReady = 1'b1;
        start_op(24'h000001, 24'h000002);
        bus.inValid = 1'b1;
        bus.mulIn1  = 24'h123456;
        bus.mulIn2  = 24'h000010;
        wait_valid(e);
        chk("b2b_first", 64'(bus.mulOut), 64'h2);
        @(posedge clock); #1;
        chk("b2b_no_bubble_busy", 64'(bus.busy), 64'd1);
        bus.inValid = 1'b0;
        wait_valid(e);
        chk("b2b_second_lat", 64'(e), 64'(LAT_X10));
        chk("b2b_second", 64'(bus.mulOut), 64'h1234560);
        @(posedge clock); #1;
        bus.outReady = 1'b0;

        // Reset pulse during the third COMP cycle.
        start_op(24'hABCDEF, 24'hFEDCBA);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b0;
        #1;
        chk("midrst_outValid", 64'(bus.outValid), 64'd0);
        chk("midrst_busy",     64'(bus.busy),     64'd0);
        chk("midrst_inReady",  64'(bus.inReady),  64'd1);
        chk("midrst_mulOut",   64'(bus.mulOut),   64'd0);
        @(posedge clock); #1;
        resetN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("midrst_no_valid", 64'(bus.outValid), 64'd0);
        end

        // Flush while a result is waiting.
        start_op(24'h000123, 24'h000456);
        wait_valid(e);
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        chk("flush_outValid", 64'(bus.outValid), 64'd0);
        chk("flush_inReady",  64'(bus.inReady),  64'd1);

        // Narrow instance: WIDTH=23.
        bus23.mulIn1  = 23'h7FFFFF;
        bus23.mulIn2  = 23'h7FFFFF;
        bus23.inValid = 1'b1;
        chk("w23_ready", 64'(bus23.inReady), 64'd1);
        @(posedge clock); #1;
        bus23.inValid = 1'b0;
        e = 0;
        while (!bus23.outValid && e < 60) begin
            @(posedge clock); #1;
            e++;
        end
        chk("w23_latency", 64'(e), 64'd6);
        chk("w23_product", 64'(bus23.mulOut), 64'h3FFFFF000001);
        bus23.outReady = 1'b1;
        @(posedge clock); #1;
        bus23.outReady = 1'b0;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            bus.mulIn1 = 24'($urandom);
            case ($urandom_range(0, 2))
                0:       bus.mulIn2 = 24'($urandom);
                1:       bus.mulIn2 = 24'($urandom) >> $urandom_range(0, 23);
                default: bus.mulIn2 = 24'd0;
            endcase
            bus.inValid  = ($urandom_range(0, 3) != 0);
            bus.outReady = ($urandom_range(0, 2) != 0);
            bus.flush    = ($urandom_range(0, 40) == 0);
            @(posedge clock); #1;
        end
        bus.inValid  = 1'b0;
        bus.flush    = 1'b0;
        bus.outReady = 1'b1;
        repeat (10) @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
